// File: rtl/shift_add_mul_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs : shared constants and types for the shift-add multiplier.
//   ALU_WIDTH : datapath width of the shared adder (only 32 is supported)
//   state_t   : sequencer state encoding (IDLE=0, RUN=1, DONE=2; 3 unused)
// ---------------------------------------------------------------------------
package alu_defs;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul_sequencer_adder.sv
// ---------------------------------------------------------------------------
// adder_32bit : plain 32-bit ripple/carry adder.
//   a, b     : input  [31:0]  addends
//   carryIn  : input          carry into bit 0
//   sum      : output [31:0]  a + b + carryIn (low 32 bits)
//   carryOut : output         carry out of bit 31
// ---------------------------------------------------------------------------
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryIn,
  output logic [31:0] sum,
  output logic        carryOut
);

  assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carryIn};

endmodule

// File: rtl/shift_add_mul_sequencer_mux.sv
// ---------------------------------------------------------------------------
// mux_2x1_32bit : 32-bit two-way selector.
//   sel : input         0 -> in0, 1 -> in1
//   in0 : input  [31:0]
//   in1 : input  [31:0]
//   out : output [31:0]
// ---------------------------------------------------------------------------
module mux_2x1_32bit (
  input  logic        sel,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [31:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/shift_add_mul_sequencer.sv
// ---------------------------------------------------------------------------
// shift_add_mul_sequencer : multi-cycle unsigned multiplier. One shared 32-bit
// adder is stepped through WIDTH shift-add iterations to form a 2*WIDTH-bit
// product. Valid/ready handshakes on operand and result sides.
//   clk, reset              : clock, synchronous active-high reset
//   inValid / inReady       : operand handshake (accepted only in IDLE)
//   multiplicand, multiplier: unsigned operands, sampled on the accept edge
//   outValid / outReady     : result handshake; product held until taken
//   product                 : multiplicand * multiplier
//   busy                    : high while in RUN or DONE
// ---------------------------------------------------------------------------
module shift_add_mul_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               outValid,
  input  logic               outReady,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     zero_word;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;

  assign zero_word = '0;

  // Addend is the multiplicand when the current multiplier bit is set.
  mux_2x1_32bit u_mux (
    .sel (lo_q[0]),
    .in0 (zero_word),
    .in1 (mcand_q),
    .out (addend)
  );

  adder_32bit u_adder (
    .a        (hi_q),
    .b        (addend),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (carry)
  );

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    count_d     = count_q;
    product_d   = product_q;

    case (state_q)
      IDLE: begin
        if (inValid && in_ready_q) begin
          mcand_d = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry-out becomes the new top bit of hi, so nothing is lost;
        // consumed multiplier bits fall off the bottom of lo.
        hi_d    = {carry, sum[WIDTH-1:1]};
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result is captured on the first DONE cycle and presented the cycle
    // after, so the product register never holds a partial sum while valid.
    if (state_q == DONE && !out_valid_q) begin
      product_d = {hi_q, lo_q};
    end
    out_valid_d = (state_q == DONE) && !(out_valid_q && outReady);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
    end
  end

  assign inReady  = in_ready_q;
  assign outValid = out_valid_q;
  assign busy     = busy_q;
  assign product  = product_q;

endmodule
